// File: rtl/fetch_pc_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/valid handshake plus the
// decoder-facing instruction, branch/halt controls and PC writeback value.
interface fetch_pc_unit_if;
    logic [15:0] imem_addr;
    logic        imem_re;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_plus2;
    logic [1:0]  branch;
    logic        halt;
    logic [2:0]  flags;
    logic [15:0] branch_reg;

    // master: the fetch unit; slave: memory plus decoder/register file
    modport master (
        output imem_addr, imem_re, instr, instr_valid, pc_plus2,
        input  imem_data, imem_valid, branch, halt, flags, branch_reg
    );

    modport slave (
        input  imem_addr, imem_re, instr, instr_valid, pc_plus2,
        output imem_data, imem_valid, branch, halt, flags, branch_reg
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction fetch and next-PC sequencer: one req/valid fetch per instruction,
// then resolves halt / conditional B / BR from the decoder in the EXEC cycle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | one cycle after reset release, before the first request
// S_REQ    | imem_re pulse with imem_addr = pc, wait counter cleared
// S_WAIT   | waiting for imem_valid; timeout after MAX_WAIT cycles
// S_EXEC   | instr_valid pulse, decoder outputs sampled, pc updated
// S_HALTED | terminal (HLT or fetch timeout); left only by reset
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  MAX_WAIT = 8'd255
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master bus,
    output logic            halted,
    output logic            fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALTED
    } fetchState_e;

    fetchState_e state;
    fetchState_e stateNext;

    logic [15:0] pc;
    logic [15:0] pcNext;
    logic [15:0] instrQ;
    logic [15:0] instrNext;
    logic [7:0]  waitCnt;
    logic [7:0]  waitCntNext;
    logic [7:0]  waitInc;
    logic        fetchErr;
    logic        fetchErrNext;

    logic        flagZ;
    logic        flagV;
    logic        flagN;
    logic        condMet;
    logic [15:0] pcPlus2;
    logic [15:0] branchOffset;
    logic [15:0] bTarget;
    logic [15:0] brTarget;

    assign {flagZ, flagV, flagN} = bus.flags;

    // Condition field ccc = instr[11:9], evaluated against the live flags.
    always_comb begin
        condMet = 1'b0;
        case (instrQ[11:9])
            3'b000:  condMet = ~flagZ;
            3'b001:  condMet = flagZ;
            3'b010:  condMet = ~flagZ & ~flagN;
            3'b011:  condMet = flagN;
            3'b100:  condMet = flagZ | (~flagZ & ~flagN);
            3'b101:  condMet = flagN | flagZ;
            3'b110:  condMet = flagV;
            default: condMet = 1'b1;
        endcase
    end

    // 9-bit word offset, sign-extended and scaled to bytes; wraps mod 2^16.
    assign pcPlus2      = pc + 16'd2;
    assign branchOffset = {{6{instrQ[8]}}, instrQ[8:0], 1'b0};
    assign bTarget      = pcPlus2 + branchOffset;
    assign brTarget     = bus.branch_reg & 16'hFFFE;
    assign waitInc      = waitCnt + 8'd1;

    always_comb begin
        stateNext    = state;
        pcNext       = pc;
        instrNext    = instrQ;
        waitCntNext  = waitCnt;
        fetchErrNext = fetchErr;
        unique case (state)
            S_IDLE: begin
                stateNext = S_REQ;
            end
            S_REQ: begin
                stateNext   = S_WAIT;
                waitCntNext = 8'd0;
            end
            S_WAIT: begin
                if (bus.imem_valid) begin
                    instrNext = bus.imem_data;
                    stateNext = S_EXEC;
                end else begin
                    waitCntNext = waitInc;
                    if (waitInc == MAX_WAIT) begin
                        fetchErrNext = 1'b1;
                        stateNext    = S_HALTED;
                    end
                end
            end
            S_EXEC: begin
                stateNext = S_REQ;
                if (bus.halt) begin
                    stateNext = S_HALTED;
                end else if (bus.branch == 2'b11 && condMet) begin
                    pcNext = bTarget;
                end else if (bus.branch == 2'b10 && condMet) begin
                    pcNext = brTarget;
                end else begin
                    pcNext = pcPlus2;
                end
            end
            S_HALTED: begin
                stateNext = S_HALTED;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            instrQ   <= 16'h0000;
            waitCnt  <= 8'd0;
            fetchErr <= 1'b0;
        end else begin
            state    <= stateNext;
            pc       <= pcNext;
            instrQ   <= instrNext;
            waitCnt  <= waitCntNext;
            fetchErr <= fetchErrNext;
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.imem_re     = (state == S_REQ);
    assign bus.instr       = instrQ;
    assign bus.instr_valid = (state == S_EXEC);
    assign bus.pc_plus2    = pcPlus2;
    assign halted          = (state == S_HALTED);
    assign fetch_err       = fetchErr;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: a transaction-level PC model predicts
// every fetch address, delivered instruction and halt/timeout behaviour.
module tb_fetch_pc_unit;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          MAXW   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic halted;
    logic fetch_err;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC(RST_PC),
        .MAX_WAIT(8'(MAXW))
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .halted   (halted),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] expPc;
    logic [15:0] lastInstr;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit condTrue(input logic [2:0] ccc, input logic [2:0] fl);
        bit z, v, n;
        z = fl[2];
        v = fl[1];
        n = fl[0];
        case (ccc)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] nextPc(input logic [15:0] pc, input logic [15:0] ins,
                                           input logic [1:0] br, input logic [2:0] fl,
                                           input logic [15:0] breg);
        int off;
        int tmp;
        bit taken;
        taken = condTrue(ins[11:9], fl);
        if (br == 2'b11 && taken) begin
            off = int'(ins[8:0]);
            if (off >= 256) off -= 512;
            tmp = int'(pc) + 2 + 2 * off;
            return tmp[15:0];
        end
        if (br == 2'b10 && taken) return 16'((int'(breg) / 2) * 2);
        tmp = int'(pc) + 2;
        return tmp[15:0];
    endfunction

    task automatic noiseDecoder();
        bus.branch     = 2'($urandom_range(0, 3));
        bus.halt       = 1'($urandom_range(0, 1));
        bus.flags      = 3'($urandom_range(0, 7));
        bus.branch_reg = 16'($urandom);
    endtask

    task automatic waitReq(input string tag);
        int n = 0;
        while (bus.imem_re !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, 32'(bus.imem_re), 32'd1);
    endtask

    task automatic checkResetVals(input string tag);
        checkVal({tag, "_re"},     32'(bus.imem_re),     32'd0);
        checkVal({tag, "_addr"},   32'(bus.imem_addr),   32'(RST_PC));
        checkVal({tag, "_instr"},  32'(bus.instr),       32'd0);
        checkVal({tag, "_ivalid"}, 32'(bus.instr_valid), 32'd0);
        checkVal({tag, "_halted"}, 32'(halted),          32'd0);
        checkVal({tag, "_ferr"},   32'(fetch_err),       32'd0);
    endtask

    // One complete fetch: REQ observed, valid after lat WAIT cycles, EXEC resolved.
    task automatic runInstr(input logic [15:0] data, input int lat, input logic [1:0] br,
                            input logic hlt, input logic [2:0] fl, input logic [15:0] breg);
        waitReq("req_seen");
        checkVal("imem_addr", 32'(bus.imem_addr), 32'(expPc));
        bus.imem_valid = 1'($urandom_range(0, 1));
        bus.imem_data  = 16'($urandom);
        noiseDecoder();
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            checkVal("wait_re", 32'(bus.imem_re), 32'd0);
            checkVal("wait_ivalid", 32'(bus.instr_valid), 32'd0);
            checkVal("instr_hold", 32'(bus.instr), 32'(lastInstr));
            checkVal("wait_ferr", 32'(fetch_err), 32'd0);
            bus.imem_valid = (i == lat);
            bus.imem_data  = (i == lat) ? data : 16'($urandom);
            noiseDecoder();
        end
        @(negedge clk);
        checkVal("exec_ivalid", 32'(bus.instr_valid), 32'd1);
        checkVal("exec_instr", 32'(bus.instr), 32'(data));
        checkVal("pc_plus2", 32'(bus.pc_plus2), 32'(16'(expPc + 16'd2)));
        lastInstr      = data;
        bus.branch     = br;
        bus.halt       = hlt;
        bus.flags      = fl;
        bus.branch_reg = breg;
        bus.imem_valid = 1'($urandom_range(0, 1));
        bus.imem_data  = 16'($urandom);
        if (!hlt) expPc = nextPc(expPc, data, br, fl, breg);
        @(negedge clk);
        if (hlt) begin
            checkVal("halt_halted", 32'(halted), 32'd1);
            checkVal("halt_re", 32'(bus.imem_re), 32'd0);
        end else begin
            checkVal("back_to_req", 32'(bus.imem_re), 32'd1);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetVals("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expPc = RST_PC;
        lastInstr = 16'h0000;
        @(negedge clk);
        checkVal("req_after_rst", 32'(bus.imem_re), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.imem_data  = 16'h0;
        bus.imem_valid = 1'b0;
        bus.branch     = 2'b00;
        bus.halt       = 1'b0;
        bus.flags      = 3'b000;
        bus.branch_reg = 16'h0;
        expPc = RST_PC;
        lastInstr = 16'h0000;
        #1;
        checkResetVals("por");
        doReset();

        // Straight-line fetches, single-cycle memory
        for (int i = 0; i < 3; i++) runInstr(16'($urandom) & 16'h01FF, 1, 2'b00, 1'b0, 3'($urandom), 16'h0);

        // Directed branches: B back/forward at 0x0010, BR odd target, B wrap at 0xFFFE
        runInstr(16'h0E00, 1, 2'b10, 1'b0, 3'b000, 16'h0011);
        runInstr(16'hC3FE, 2, 2'b11, 1'b0, 3'b100, 16'h0);
        checkVal("b_taken_addr", 32'(bus.imem_addr), 32'h000E);
        runInstr(16'h0E00, 1, 2'b10, 1'b0, 3'b000, 16'h0011);
        runInstr(16'hC3FE, 1, 2'b11, 1'b0, 3'b000, 16'h0);
        checkVal("b_not_taken_addr", 32'(bus.imem_addr), 32'h0012);
        runInstr(16'h0E00, 3, 2'b10, 1'b0, 3'b000, 16'h1235);
        checkVal("br_odd_addr", 32'(bus.imem_addr), 32'h1234);
        runInstr(16'h0E00, 1, 2'b10, 1'b0, 3'b000, 16'hFFFF);
        runInstr(16'hCE01, 4, 2'b11, 1'b0, 3'b000, 16'h0);
        checkVal("b_wrap_addr", 32'(bus.imem_addr), 32'h0002);

        // Randomized instruction stream
        for (int i = 0; i < 200; i++)
            runInstr(16'($urandom), int'($urandom_range(1, MAXW)), 2'($urandom_range(0, 3)),
                     1'b0, 3'($urandom_range(0, 7)), 16'($urandom));

        // Halt with a simultaneous taken B: halt wins, terminal for 20 cycles
        begin
            logic [15:0] haltPc;
            haltPc = expPc;
            runInstr(16'hCE05, 1, 2'b11, 1'b1, 3'b111, 16'h4444);
            for (int i = 0; i < 20; i++) begin
                bus.imem_valid = 1'($urandom_range(0, 1));
                bus.imem_data  = 16'($urandom);
                noiseDecoder();
                @(negedge clk);
                checkVal("halted_hold", 32'(halted), 32'd1);
                checkVal("halted_re", 32'(bus.imem_re), 32'd0);
                checkVal("halted_ivalid", 32'(bus.instr_valid), 32'd0);
                checkVal("halted_pc", 32'(bus.imem_addr), 32'(haltPc));
                checkVal("halted_instr", 32'(bus.instr), 32'h0000CE05);
            end
        end

        // Memory timeout after MAXW WAIT cycles
        bus.imem_valid = 1'b0;
        doReset();
        checkVal("to_addr", 32'(bus.imem_addr), 32'(RST_PC));
        bus.imem_valid = 1'b0;
        for (int k = 1; k <= MAXW; k++) begin
            @(negedge clk);
            checkVal("to_wait_ferr", 32'(fetch_err), 32'd0);
            checkVal("to_wait_halted", 32'(halted), 32'd0);
        end
        @(negedge clk);
        checkVal("to_ferr", 32'(fetch_err), 32'd1);
        checkVal("to_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.imem_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkVal("to_ferr_sticky", 32'(fetch_err), 32'd1);
            checkVal("to_halted_sticky", 32'(halted), 32'd1);
            checkVal("to_re", 32'(bus.imem_re), 32'd0);
        end

        // Reset dropped in WAIT after one delivered instruction
        bus.imem_valid = 1'b0;
        doReset();
        runInstr(16'hA5A5, 1, 2'b00, 1'b0, 3'b000, 16'h0);
        bus.imem_valid = 1'b0;
        @(negedge clk);
        checkVal("mid_in_wait", 32'(bus.imem_re), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetVals("mid_rst");
        bus.imem_valid = 1'b1;
        bus.imem_data  = 16'h5A5A;
        repeat (2) @(negedge clk);
        checkVal("mid_rst_ivalid", 32'(bus.instr_valid), 32'd0);
        rst_n = 1'b1;
        expPc = RST_PC;
        lastInstr = 16'h0000;
        begin
            int n = 0;
            bit sawValid = 1'b0;
            while (bus.imem_re !== 1'b1 && n < 8) begin
                @(negedge clk);
                if (bus.instr_valid === 1'b1) sawValid = 1'b1;
                n++;
            end
            checkVal("mid_no_ivalid", 32'(sawValid), 32'd0);
        end
        runInstr(16'h1357, 2, 2'b00, 1'b0, 3'b000, 16'h0);
        checkVal("mid_restart_addr", 32'(bus.imem_addr), 32'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and next-PC sequencer for the 16-bit single-issue core.
- Fetches one 16-bit instruction per pass from instruction memory over a req/valid handshake.
- Presents the instruction to the control decoder, then takes back the decoder's branch[1:0] and halt controls to choose the next PC.
- Sits between instruction memory and the control decoder / register file. It is the producer of the opcode and the consumer of the decoder's branch and halt outputs.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MAX_WAIT, 8'd255, number of WAIT cycles without imem_valid before fetch error.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_addr  output  16  fetch address, equal to current PC.
- imem_re  output  1  fetch request, one-cycle pulse.
- imem_data  input  16  instruction word returned by memory.
- imem_valid  input  1  imem_data valid; accepted only in WAIT.
- instr  output  16  latched instruction, driven to the decoder.
- instr_valid  output  1  instr is live; decoder outputs are sampled in this cycle.
- pc_plus2  output  16  PC+2 of the current instruction, used for PCS writeback.
- branch  input  2  from decoder: 11 = B (PC-relative), 10 = BR (register), 0x = no branch.
- halt  input  1  from decoder: HLT.
- flags  input  3  {Z,V,N} from the flag register.
- branch_reg  input  16  rs value, used as the BR target.
- halted  output  1  core stopped.
- fetch_err  output  1  sticky memory-timeout error.

Behaviour:
- Reset values (async, rst_n=0):
  - State machine in IDLE; pc = RESET_PC.
  - imem_re = 0, imem_addr = RESET_PC.
  - instr = 16'h0000, instr_valid = 0.
  - halted = 0, fetch_err = 0, wait counter = 0.
- Reset asserted mid-fetch aborts immediately: no instruction is delivered and any pending imem_valid is ignored.
- States: IDLE, REQ, WAIT, EXEC, HALTED.
- IDLE → REQ unconditionally, on the first clock after rst_n rises.
- REQ:
  - imem_re = 1 and imem_addr = pc for exactly one cycle.
  - Go to WAIT; clear the wait counter.
- WAIT:
  - If imem_valid = 1: latch imem_data into instr, go to EXEC.
  - Otherwise increment the counter. When the counter reaches MAX_WAIT, set fetch_err = 1 and go to HALTED.
  - imem_valid in any other state is ignored.
- EXEC:
  - instr_valid = 1 for exactly one cycle; pc_plus2 = pc + 2.
  - branch, halt, flags and branch_reg are all sampled in this cycle.
  - Condition ccc = instr[11:9]:
    - 000 NE: Z=0.
    - 001 EQ: Z=1.
    - 010 GT: Z=0 and N=0.
    - 011 LT: N=1.
    - 100 GE: Z=1, or (Z=0 and N=0).
    - 101 LE: N=1 or Z=1.
    - 110 OV: V=1.
    - 111: always.
  - Next-PC priority:
    1. halt = 1: pc unchanged, go to HALTED. Halt wins over any simultaneous branch.
    2. branch = 11 and condition true: pc = pc + 2 + (sign_extend(instr[8:0]) << 1).
    3. branch = 10 and condition true: pc = {branch_reg[15:1], 1'b0}. An odd target has bit 0 forced to 0.
    4. Otherwise: pc = pc + 2.
  - All PC arithmetic is modulo 2^16; wrap-around is silent.
  - After a non-halt EXEC, go to REQ.
- HALTED:
  - halted = 1, imem_re = 0, instr_valid = 0.
  - Terminal state; left only by reset.
- Throughput: 3 cycles per instruction minimum (REQ, WAIT with valid, EXEC), plus one cycle for each extra WAIT cycle.
- instr holds its value between EXEC cycles; only instr_valid qualifies it.

Test Plan:
- Reset release with memory returning valid one cycle after each request → imem_re pulses with imem_addr 0x0000, 0x0002, 0x0004; instr_valid asserts every 3rd cycle; pc_plus2 = 0x0002, 0x0004, 0x0006.
- B at PC 0x0010, instr = 0xC3FE (ccc = 001, imm = −2), branch = 11, Z = 1 → next imem_addr = 0x000E. Same instruction with Z = 0 → next imem_addr = 0x0012.
- BR, ccc = 111, branch = 10, branch_reg = 0x1235 → next imem_addr = 0x1234. Separately, B at PC 0xFFFE with imm = +1 → target wraps to 0x0002.
- halt = 1 and branch = 11 in the same EXEC → halted = 1 the next cycle; imem_re stays 0 and pc is unchanged for 20 cycles; imem_valid pulses in this period are ignored.
- MAX_WAIT = 4 and imem_valid never asserted → fetch_err = 1 and halted = 1 after 4 WAIT cycles; both stay 1 until reset.
- rst_n dropped during WAIT, then imem_valid raised → all outputs return to reset values asynchronously, no instr_valid pulse occurs, and the fetch restarts at RESET_PC.
